// File: rtl/mm_mac_scheduler.sv
// mm_mac_scheduler
//   Computes C = A x B for N x N unsigned matrices on a single shared
//   multiply-accumulate unit. For each output element (i,j) it walks k over
//   0..N-1, fetching A[i][k] and B[k][j] through combinational index/data
//   ports, accumulates the N products, then emits one result write.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   reset          synchronous active-high reset
//   start          begin a product (accepted only while idle)
//   abort          synchronous cancel, honoured in every state
//   a_idx/b_idx    operand indices (row-major i*N+k and k*N+j)
//   a_data/b_data  operand values returned for a_idx/b_idx in the same cycle
//   c_we           result write strobe
//   c_idx/c_data   result index i*N+j and value, driven while c_we=1
//   busy           high whenever not idle
//   done           single-cycle pulse after the last write
module mm_mac_scheduler #(
  parameter int N     = 3,
  parameter int WIDTH = 8,
  parameter int ACC_W = 2*WIDTH+2,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [IDX_W-1:0] a_idx,
  output logic [IDX_W-1:0] b_idx,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  output logic             c_we,
  output logic [IDX_W-1:0] c_idx,
  output logic [ACC_W-1:0] c_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] N_IDX = IDX_W'(N);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N-1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   i_q, i_d;
  logic [IDX_W-1:0]   j_q, j_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic [ACC_W-1:0]   acc_q, acc_d;

  logic [2*WIDTH-1:0] prod;
  logic [ACC_W-1:0]   prod_ext;

  // Operands are widened before the multiply so the full 2*WIDTH product is kept.
  assign prod     = {{WIDTH{1'b0}}, a_data} * {{WIDTH{1'b0}}, b_data};
  assign prod_ext = {{(ACC_W-2*WIDTH){1'b0}}, prod};

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;

    case (state_q)
      S_IDLE: begin
        i_d = '0;
        j_d = '0;
        k_d = '0;
        if (start) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // First product of an element overwrites; no separate clear cycle needed.
        if (k_q == '0) begin
          acc_d = prod_ext;
        end else begin
          acc_d = acc_q + prod_ext;
        end
        if (k_q == LAST) begin
          k_d     = '0;
          state_d = S_WRITE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      S_WRITE: begin
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            // Wrap i as well so the scheduler re-enters idle with all-zero indices.
            i_d     = '0;
            state_d = S_DONE;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = S_RUN;
          end
        end else begin
          j_d     = j_q + 1'b1;
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Cancel overrides every transition, including a start seen while idle.
    if (abort) begin
      state_d = S_IDLE;
      i_d     = '0;
      j_d     = '0;
      k_d     = '0;
      acc_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
    end
  end

  // Operand indices follow the counters; they are zero while idle because
  // the counters are held at zero there.
  assign a_idx = i_q * N_IDX + k_q;
  assign b_idx = k_q * N_IDX + j_q;

  // Result-side outputs depend only on registered state, never on inputs.
  assign c_we   = (state_q == S_WRITE);
  assign c_idx  = c_we ? (i_q * N_IDX + j_q) : '0;
  assign c_data = c_we ? acc_q : '0;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_mm_mac_scheduler.sv
module tb_mm_mac_scheduler;
  localparam int N  = 3;
  localparam int W  = 8;
  localparam int AW = 18;
  localparam int IW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, abort;
  logic [IW-1:0] a_idx, b_idx, c_idx;
  logic [W-1:0]  a_data, b_data;
  logic          c_we, busy, done;
  logic [AW-1:0] c_data;

  logic          start2, abort2;
  logic [IW-1:0] a_idx2, b_idx2, c_idx2;
  logic [W-1:0]  a_data2, b_data2;
  logic          c_we2, busy2, done2;
  logic [AW-1:0] c_data2;

  logic [W-1:0] ma[16];
  logic [W-1:0] mb[16];
  logic [W-1:0] m2a[16];
  logic [W-1:0] m2b[16];

  assign a_data  = ma[a_idx];
  assign b_data  = mb[b_idx];
  assign a_data2 = m2a[a_idx2];
  assign b_data2 = m2b[b_idx2];

  mm_mac_scheduler #(.N(N), .WIDTH(W), .ACC_W(AW), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .a_idx(a_idx), .b_idx(b_idx), .a_data(a_data), .b_data(b_data),
    .c_we(c_we), .c_idx(c_idx), .c_data(c_data), .busy(busy), .done(done)
  );

  mm_mac_scheduler #(.N(2), .WIDTH(W), .ACC_W(AW), .IDX_W(IW)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2),
    .a_idx(a_idx2), .b_idx(b_idx2), .a_data(a_data2), .b_data(b_data2),
    .c_we(c_we2), .c_idx(c_idx2), .c_data(c_data2), .busy(busy2), .done(done2)
  );

  typedef struct packed {
    logic [8:0][7:0]  a;
    logic [8:0][7:0]  b;
    logic [8:0][17:0] c;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs[NV];

  // Hand-computed vectors: identity, A x A^T, saturated operands,
  // ones x [1..9], [1..9] x [9..1].
  int ta[NV][9] = '{
    '{1,0,0, 0,1,0, 0,0,1},
    '{1,2,3, 4,5,6, 7,8,9},
    '{255,255,255, 255,255,255, 255,255,255},
    '{1,1,1, 1,1,1, 1,1,1},
    '{1,2,3, 4,5,6, 7,8,9}
  };
  int tb_[NV][9] = '{
    '{1,0,0, 0,1,0, 0,0,1},
    '{1,4,7, 2,5,8, 3,6,9},
    '{255,255,255, 255,255,255, 255,255,255},
    '{1,2,3, 4,5,6, 7,8,9},
    '{9,8,7, 6,5,4, 3,2,1}
  };
  int tc[NV][9] = '{
    '{1,0,0, 0,1,0, 0,0,1},
    '{14,32,50, 32,77,122, 50,122,194},
    '{195075,195075,195075, 195075,195075,195075, 195075,195075,195075},
    '{12,15,18, 12,15,18, 12,15,18},
    '{30,24,18, 84,69,54, 138,114,90}
  };

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int cyc, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at T+%0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input int cyc);
    chk("busy_zero",   cyc, busy,   0);
    chk("done_zero",   cyc, done,   0);
    chk("c_we_zero",   cyc, c_we,   0);
    chk("c_idx_zero",  cyc, c_idx,  0);
    chk("c_data_zero", cyc, c_data, 0);
    chk("a_idx_zero",  cyc, a_idx,  0);
    chk("b_idx_zero",  cyc, b_idx,  0);
  endtask

  // Starts a product in the current (idle) cycle T and checks every cycle
  // T+1..T+38 against the schedule. kill_at>0 asserts abort (or reset) in
  // cycle T+kill_at and expects everything idle and zero one cycle later.
  task automatic run_check(input int v, input int kill_at, input bit kill_is_reset, input bit hold);
    for (int x = 0; x < 16; x++) begin
      ma[x] = (x < 9) ? vecs[v].a[x] : 8'd0;
      mb[x] = (x < 9) ? vecs[v].b[x] : 8'd0;
    end
    start = 1'b1;
    for (int c = 1; c <= 38; c++) begin
      tick();
      if (!hold) start = 1'b0;
      if (kill_at != 0 && c == kill_at + 1) begin
        abort = 1'b0;
        reset = 1'b0;
        chk_all_zero(c);
        $display("vec %0d killed at T+%0d, idle at T+%0d", v, kill_at, c);
        return;
      end
      begin
        int  e, ph;
        bit  we_exp;
        e      = (c - 1) / 4;
        ph     = (c - 1) % 4;
        we_exp = (c % 4 == 0) && (c <= 36);
        chk("busy", c, busy, (c <= 37) ? 1 : 0);
        chk("done", c, done, (c == 37) ? 1 : 0);
        chk("c_we", c, c_we, we_exp ? 1 : 0);
        if (we_exp) begin
          chk("c_idx",  c, c_idx,  c / 4 - 1);
          chk("c_data", c, c_data, vecs[v].c[c/4-1]);
          $display("vec %0d write T+%0d c_idx=%0d c_data=%0d", v, c, c_idx, c_data);
        end
        if (c <= 36 && ph < 3) begin
          chk("a_idx", c, a_idx, (e / 3) * 3 + ph);
          chk("b_idx", c, b_idx, ph * 3 + e % 3);
        end
      end
      if (c == kill_at) begin
        if (kill_is_reset) reset = 1'b1;
        else abort = 1'b1;
      end
    end
  endtask

  initial begin
    for (int v = 0; v < NV; v++) begin
      for (int x = 0; x < 9; x++) begin
        vecs[v].a[x] = 8'(ta[v][x]);
        vecs[v].b[x] = 8'(tb_[v][x]);
        vecs[v].c[x] = 18'(tc[v][x]);
      end
    end
    for (int x = 0; x < 16; x++) begin
      ma[x] = '0; mb[x] = '0; m2a[x] = '0; m2b[x] = '0;
    end
    reset = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk_all_zero(0);
    $display("reset state checked");

    for (int v = 0; v < NV; v++) run_check(v, 0, 1'b0, 1'b0);

    // Abort mid-run, then an immediate restart from the idle cycle.
    run_check(0, 10, 1'b0, 1'b0);
    run_check(0, 0, 1'b0, 1'b0);

    // Reset mid-run, then restart.
    run_check(1, 20, 1'b1, 1'b0);
    run_check(1, 0, 1'b0, 1'b0);

    // start held high: ignored while busy, accepted again at T+38.
    run_check(3, 0, 1'b0, 1'b1);
    tick();
    chk("hold_rearm_busy", 39, busy, 1);
    chk("hold_rearm_we",   39, c_we, 0);
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("hold_abort_busy", 40, busy, 0);
    $display("start-held rerun accepted at T+38 and aborted");

    // start and abort together while idle: abort wins.
    start = 1'b1;
    abort = 1'b1;
    tick();
    chk("start_abort_busy1", 1, busy, 0);
    tick();
    chk("start_abort_busy2", 2, busy, 0);
    start = 1'b0;
    abort = 1'b0;
    $display("start+abort in idle stayed idle");

    // N=2 instance with identity operands.
    m2a[0] = 8'd1; m2a[3] = 8'd1;
    m2b[0] = 8'd1; m2b[3] = 8'd1;
    start2 = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      bit we_exp;
      int idx;
      tick();
      start2 = 1'b0;
      we_exp = (c % 3 == 0) && (c <= 12);
      chk("n2_busy", c, busy2, (c <= 13) ? 1 : 0);
      chk("n2_done", c, done2, (c == 13) ? 1 : 0);
      chk("n2_c_we", c, c_we2, we_exp ? 1 : 0);
      if (we_exp) begin
        idx = c / 3 - 1;
        chk("n2_c_idx",  c, c_idx2,  idx);
        chk("n2_c_data", c, c_data2, (idx == 0 || idx == 3) ? 1 : 0);
        $display("n2 write T+%0d c_idx=%0d c_data=%0d", c, c_idx2, c_data2);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
